// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32 core.
// Holds the PC, captures the fetched word, and honours stall and branch redirect.
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    function automatic logic [31:0] sat_inc(input logic [31:0] count);
        return (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            // Redirect wins over stall: the wrong-path word in ID is replaced by a bubble.
            pc          <= {branch_target[XLEN-1:2], 2'b00};
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            flush_count <= sat_inc(flush_count);
        end else if (stall) begin
            stall_count <= sat_inc(stall_count);
        end else begin
            pc          <= pc + PC_STEP;
            if_id_pc    <= pc;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

    assign imem_addr = pc;
    assign opcode    = if_id_instr[6:0];
    assign funct3    = if_id_instr[14:12];
    assign rd        = if_id_instr[11:7];
    assign rs1       = if_id_instr[19:15];
    assign rs2       = if_id_instr[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the driver queues expected post-edge state,
// a negedge monitor pops and compares it against the outputs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        v;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .opcode       (opcode),
        .funct3       (funct3),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: two program words, everything else is addr ^ 0x5A5A0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk("pc",          pc,                   mon_e.pc);
            chk("imem_addr",   imem_addr,            mon_e.pc);
            chk("if_id_pc",    if_id_pc,             mon_e.ipc);
            chk("if_id_instr", if_id_instr,          mon_e.instr);
            chk("if_id_valid", 32'(if_id_valid),     32'(mon_e.v));
            chk("opcode",      32'(opcode),          32'(mon_e.instr[6:0]));
            chk("funct3",      32'(funct3),          32'(mon_e.instr[14:12]));
            chk("rd",          32'(rd),              32'(mon_e.instr[11:7]));
            chk("rs1",         32'(rs1),             32'(mon_e.instr[19:15]));
            chk("rs2",         32'(rs2),             32'(mon_e.instr[24:20]));
            chk("stall_count", stall_count,          mon_e.sc);
            chk("flush_count", flush_count,          mon_e.fc);
        end
    end

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic [31:0] e_ipc,
                        input logic [31:0] e_instr, input logic e_v,
                        input logic [31:0] e_sc, input logic [31:0] e_fc);
        exp_t e;
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        e.due   = cyc + 1;
        e.pc    = e_pc;
        e.ipc   = e_ipc;
        e.instr = e_instr;
        e.v     = e_v;
        e.sc    = e_sc;
        e.fc    = e_fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        //    rst  stl  br   target        pc            if_id_pc      instr         v     sc  fc
        step(1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0000_0013,1'b0, 0,  0);
        step(1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0000_0013,1'b0, 0,  0);
        // free run from reset
        step(1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h0,        32'h0050_0093,1'b1, 0,  0);
        step(1'b0,1'b0,1'b0,32'h0,        32'h8,        32'h4,        32'h00A0_0113,1'b1, 0,  0);
        // three-cycle stall at pc=8
        step(1'b0,1'b1,1'b0,32'h0,        32'h8,        32'h4,        32'h00A0_0113,1'b1, 1,  0);
        step(1'b0,1'b1,1'b0,32'h0,        32'h8,        32'h4,        32'h00A0_0113,1'b1, 2,  0);
        step(1'b0,1'b1,1'b0,32'h0,        32'h8,        32'h4,        32'h00A0_0113,1'b1, 3,  0);
        step(1'b0,1'b0,1'b0,32'h0,        32'hC,        32'h8,        32'h5A5A_0008,1'b1, 3,  0);
        step(1'b0,1'b0,1'b0,32'h0,        32'h10,       32'hC,        32'h5A5A_000C,1'b1, 3,  0);
        // branch to 0x43 at pc=0x10, low bits dropped
        step(1'b0,1'b0,1'b1,32'h43,       32'h40,       32'h0,        32'h0000_0013,1'b0, 3,  1);
        step(1'b0,1'b0,1'b0,32'h0,        32'h44,       32'h40,       32'h5A5A_0040,1'b1, 3,  1);
        // stall and branch together: branch wins
        step(1'b0,1'b1,1'b1,32'h100,      32'h100,      32'h0,        32'h0000_0013,1'b0, 3,  2);
        step(1'b0,1'b0,1'b0,32'h0,        32'h104,      32'h100,      32'h5A5A_0100,1'b1, 3,  2);
        // redirect to top of address space, then wrap
        step(1'b0,1'b0,1'b1,32'hFFFF_FFFF,32'hFFFF_FFFC,32'h0,        32'h0000_0013,1'b0, 3,  3);
        step(1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hFFFF_FFFC,32'hA5A5_FFFC,1'b1, 3,  3);
        step(1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h0,        32'h0050_0093,1'b1, 3,  3);
        // stall up to 5, then reset overriding stall and branch
        step(1'b0,1'b1,1'b0,32'h0,        32'h4,        32'h0,        32'h0050_0093,1'b1, 4,  3);
        step(1'b0,1'b1,1'b0,32'h0,        32'h4,        32'h0,        32'h0050_0093,1'b1, 5,  3);
        step(1'b1,1'b1,1'b1,32'h200,      32'h0,        32'h0,        32'h0000_0013,1'b0, 0,  0);
        step(1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h0,        32'h0050_0093,1'b1, 0,  0);
        step(1'b0,1'b0,1'b0,32'h0,        32'h8,        32'h4,        32'h00A0_0113,1'b1, 0,  0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RV32 core with the neuromorphic (WVR/SVR) extension. It holds the program counter and drives the instruction-memory address. It captures the fetched word and presents decoded opcode, funct3 and register fields to the control unit and register file in the ID stage. It honours the hazard unit's stall and redirects on a taken branch from EX, squashing the wrong-path instruction.

## Interface
- XLEN, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  from hazard unit; hold PC and IF/ID
- branch_taken  in  1  from EX; redirect PC and flush IF/ID
- branch_target  in  XLEN  redirect address; bits [1:0] ignored (treated as 0)
- imem_addr  out  XLEN  instruction memory address (= pc)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- pc  out  XLEN  current fetch PC
- if_id_pc  out  XLEN  PC of instruction in ID
- if_id_instr  out  32  instruction in ID
- if_id_valid  out  1  ID holds a real (non-bubble) instruction
- opcode  out  7  if_id_instr[6:0]
- funct3  out  3  if_id_instr[14:12]
- rd, rs1, rs2  out  5 each  if_id_instr[11:7], [19:15], [24:20]
- stall_count  out  32  saturating count of stalled cycles
- flush_count  out  32  saturating count of branch flushes

## Operation
- One clock, one update per rising edge. Priority: rst > branch_taken > stall > advance.
- rst: pc<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_valid<=0; both counters<=0.
- branch_taken (stall ignored): pc<={branch_target[XLEN-1:2],2'b00}; if_id_instr<=NOP_INSTR; if_id_valid<=0; if_id_pc<=0; flush_count++.
- stall (no branch): pc, if_id_* all hold; stall_count++.
- advance: if_id_instr<=imem_rdata; if_id_pc<=pc; if_id_valid<=1; pc<=pc+4.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC advances to 0. No fault is raised.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Decoded field outputs are purely combinational slices of the if_id_instr register. A bubble therefore decodes as opcode 7'b0010011, funct3 0, rd 0. The control unit treats this as a harmless immediate ALU write to x0.
- imem_addr is always equal to pc, with no low-bit masking beyond redirect.

## Timing
- Fetch-to-ID latency is 1 cycle. The word at imem_addr in cycle N appears on if_id_instr after edge N.
- First fetch: the cycle after rst deasserts, imem_addr=RESET_PC. The next edge gives if_id_instr=mem[RESET_PC], if_id_valid=1, pc=RESET_PC+4.
- Redirect takes 1 cycle. If branch_taken is high in cycle N, then after edge N: pc=target, ID holds a bubble. After edge N+1, ID holds mem[target] (absent stall).
- Stall held for K cycles freezes all state for exactly K edges. stall_count increases by K. No instruction is lost or duplicated.
- Simultaneous stall and branch_taken: the branch wins. flush_count increments; stall_count does not.
- rst asserted mid-stream, including during stall or branch, overrides everything on that edge.
- All outputs are registered except the decoded slices, imem_addr and pc, which are direct register taps with no input-to-output combinational path.

## Test plan
- Reset then free-run, with mem[0]=0x00500093, mem[4]=0x00A00113. Required: after edge 1, if_id_instr=0x00500093, if_id_pc=0, opcode=0010011, rd=1. After edge 2, if_id_instr=0x00A00113, if_id_pc=4, pc=8.
- Stall for 3 cycles at pc=8. Required: pc, if_id_instr and if_id_pc unchanged for 3 edges, stall_count=3. On release, the next edge loads mem[8] and pc=12.
- branch_taken with target 0x43 at pc=0x10. Required: next edge gives pc=0x40, if_id_valid=0, if_id_instr=0x00000013, flush_count=1. The following edge gives if_id_pc=0x40.
- Stall and branch_taken both high with target 0x100. Required: pc=0x100, bubble in ID, flush_count+1, stall_count unchanged.
- Preload pc near the top by redirecting to 0xFFFF_FFFC, then advance. Required: pc wraps to 0x0, and if_id_pc=0xFFFF_FFFC.
- Assert rst during a stall with stall_count=5. Required: next edge gives pc=RESET_PC, if_id_valid=0, stall_count=0, flush_count=0.
